// File: rtl/dht11_reader.sv
`default_nettype none
// ============================================================================
// Module      : dht11_reader
// Description : DHT11 single-wire master. Issues the host start pulse, times
//               the sensor reply and 40 data bits, and checks the checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module dht11_reader #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic [39:0] data_out,
    output logic        done,
    output logic        error,
    output logic        busy
);

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_START_LOW = 4'd1;
    localparam logic [3:0] c_ST_WAIT_RESP = 4'd2;
    localparam logic [3:0] c_ST_RESP_LOW  = 4'd3;
    localparam logic [3:0] c_ST_RESP_HIGH = 4'd4;
    localparam logic [3:0] c_ST_BIT_LOW   = 4'd5;
    localparam logic [3:0] c_ST_BIT_HIGH  = 4'd6;
    localparam logic [3:0] c_ST_CHECK     = 4'd7;
    localparam logic [3:0] c_ST_FAIL      = 4'd8;

    localparam int                 c_PRE_W     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX   = c_PRE_W'(CLKS_PER_US - 1);
    localparam logic [15:0]        c_START_LOW = 16'(START_LOW_US);
    localparam logic [15:0]        c_TIMEOUT   = 16'(TIMEOUT_US);
    localparam logic [15:0]        c_THRESH    = 16'(BIT_THRESH_US);
    localparam logic [39:0]        c_FAULT     = 40'h00_0000_00FF;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [2:0]         r_sync;
    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;
    logic [15:0]        r_us_cnt;
    logic [5:0]         r_bit_cnt;
    logic [38:0]        r_shift;
    logic [39:0]        r_data;
    logic               r_error;
    logic               w_rise;
    logic               w_fall;
    logic               w_timeout;
    logic               w_bit;
    logic [39:0]        w_word;
    logic [7:0]         w_sum;

    // r_sync[1] is the synchronized pin level, r_sync[2] its previous value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], dht_in};
        end
    end

    assign w_rise = r_sync[1] & ~r_sync[2];
    assign w_fall = ~r_sync[1] & r_sync[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick    = (r_pre == c_PRE_MAX);
    assign w_timeout = (r_us_cnt == c_TIMEOUT);
    assign w_bit     = (r_us_cnt > c_THRESH);
    assign w_word    = {r_shift, w_bit};
    assign w_sum     = w_word[39:32] + w_word[31:24] + w_word[23:16] + w_word[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dht_oe      = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = c_ST_START_LOW;
            end
            c_ST_START_LOW: begin
                dht_oe = 1'b1;
                if (r_us_cnt == c_START_LOW) w_state_nxt = c_ST_WAIT_RESP;
            end
            c_ST_WAIT_RESP: begin
                if (w_fall)         w_state_nxt = c_ST_RESP_LOW;
                else if (w_timeout) w_state_nxt = c_ST_FAIL;
            end
            c_ST_RESP_LOW: begin
                if (w_rise)         w_state_nxt = c_ST_RESP_HIGH;
                else if (w_timeout) w_state_nxt = c_ST_FAIL;
            end
            c_ST_RESP_HIGH: begin
                if (w_fall)         w_state_nxt = c_ST_BIT_LOW;
                else if (w_timeout) w_state_nxt = c_ST_FAIL;
            end
            c_ST_BIT_LOW: begin
                if (w_rise)         w_state_nxt = c_ST_BIT_HIGH;
                else if (w_timeout) w_state_nxt = c_ST_FAIL;
            end
            c_ST_BIT_HIGH: begin
                if (w_fall)         w_state_nxt = (r_bit_cnt == 6'd39) ? c_ST_CHECK : c_ST_BIT_LOW;
                else if (w_timeout) w_state_nxt = c_ST_FAIL;
            end
            c_ST_CHECK: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_FAIL: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Result registers load on the edge entering CHECK/FAIL so they are valid with done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_us_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= c_FAULT;
            r_error   <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_us_cnt <= '0;
            end else if (w_tick && (r_us_cnt != 16'hFFFF)) begin
                r_us_cnt <= r_us_cnt + 1'b1;
            end

            if (r_state == c_ST_RESP_HIGH && w_fall) begin
                r_bit_cnt <= '0;
            end else if (r_state == c_ST_BIT_HIGH && w_fall) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= w_word[38:0];
            end

            if (r_state == c_ST_IDLE && start) begin
                r_error <= 1'b0;
            end

            if (w_state_nxt == c_ST_CHECK) begin
                if (w_sum == w_word[7:0]) begin
                    r_data  <= {w_word[23:16], w_word[15:8], w_word[39:32], w_word[31:24], w_word[7:0]};
                    r_error <= 1'b0;
                end else begin
                    r_data  <= c_FAULT;
                    r_error <= 1'b1;
                end
            end else if (w_state_nxt == c_ST_FAIL) begin
                r_data  <= c_FAULT;
                r_error <= 1'b1;
            end
        end
    end

    assign data_out = r_data;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dht11_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dht11_reader
// Description : Directed self-checking bench for dht11_reader with a DHT11 pin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_reader;

    localparam int CPU = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sensor;
    logic        dht_in;
    logic        dht_oe;
    logic [39:0] data_out;
    logic        done;
    logic        error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [39:0] cap_data = '0;
    logic        cap_err  = 1'b0;
    logic        cap_busy = 1'b0;

    // Open-drain wire: host pulls low when dht_oe, otherwise the sensor sets the level
    assign dht_in = dht_oe ? 1'b0 : sensor;

    always #5 clk = ~clk;

    dht11_reader #(
        .CLKS_PER_US   (CPU),
        .START_LOW_US  (20),
        .TIMEOUT_US    (200),
        .BIT_THRESH_US (40)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dht_in   (dht_in),
        .dht_oe   (dht_oe),
        .data_out (data_out),
        .done     (done),
        .error    (error),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            cap_data <= data_out;
            cap_err  <= error;
            cap_busy <= busy;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic us_wait(input int n);
        repeat (n * CPU) @(negedge clk);
    endtask

    // Start on an even cycle count so the prescaler phase makes the start pulse exactly 40 clocks
    task automatic kick();
        @(negedge clk);
        while (cyc % 2 != 0) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure_oe(input int hold_start, output int n);
        n = 0;
        while (dht_oe && n < 1000) begin
            start = (n < hold_start);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] frame, input int hi0, input int hi1, input int abort_bit);
        us_wait(30);
        sensor = 1'b0; us_wait(80);
        sensor = 1'b1; us_wait(80);
        for (int i = 39; i >= 0; i--) begin
            sensor = 1'b0; us_wait(50);
            sensor = 1'b1;
            if (39 - i == abort_bit) begin
                us_wait(10);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            us_wait(frame[i] ? hi1 : hi0);
        end
        sensor = 1'b0; us_wait(50);
        sensor = 1'b1; us_wait(5);
    endtask

    task automatic wait_done(input int prev, input string tag);
        int n;
        n = 0;
        while (done_cnt == prev && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done_cnt - prev), 64'd1);
    endtask

    task automatic good_frame(input logic [39:0] frame, input int hi0, input int hi1,
                              input logic [39:0] exp_data, input logic exp_err, input string tag);
        int n;
        int prev;
        kick();
        chk({tag, "_busy_on"}, 64'(busy), 64'd1);
        measure_oe(0, n);
        chk({tag, "_oe_len"}, 64'(n), 64'd40);
        prev = done_cnt;
        send_frame(frame, hi0, hi1, 99);
        wait_done(prev, {tag, "_done"});
        chk({tag, "_err"}, 64'(cap_err), 64'(exp_err));
        chk({tag, "_data"}, 64'(cap_data), 64'(exp_data));
        chk({tag, "_busy_at_done"}, 64'(cap_busy), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_data_hold"}, 64'(data_out), 64'(exp_data));
    endtask

    initial begin
        int n;
        int prev;
        reset  = 1'b1;
        start  = 1'b0;
        sensor = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_oe",   64'(dht_oe),   64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_done", 64'(done),     64'd0);
        chk("rst_err",  64'(error),    64'd0);
        chk("rst_data", 64'(data_out), 64'h00_0000_00FF);

        good_frame(40'h37_00_19_00_50, 26, 70, 40'h19_00_37_00_50, 1'b0, "good");
        good_frame(40'h37_00_19_00_51, 26, 70, 40'h00_0000_00FF, 1'b1, "badsum");

        // No sensor: line stays high after release
        kick();
        measure_oe(0, n);
        chk("nosens_oe_len", 64'(n), 64'd40);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("nosens_cycles", 64'(n), 64'd400);
        chk("nosens_err", 64'(error), 64'd1);
        chk("nosens_data", 64'(data_out), 64'h00_0000_00FF);
        chk("nosens_oe", 64'(dht_oe), 64'd0);
        @(negedge clk);
        chk("nosens_busy_after", 64'(busy), 64'd0);
        chk("nosens_done_after", 64'(done), 64'd0);

        // Extra starts while busy, then reset during bit 10
        kick();
        measure_oe(12, n);
        chk("abort_oe_len", 64'(n), 64'd40);
        prev = done_cnt;
        send_frame(40'h37_00_19_00_50, 26, 70, 10);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_oe", 64'(dht_oe), 64'd0);
        chk("abort_err", 64'(error), 64'd0);
        chk("abort_data", 64'(data_out), 64'h00_0000_00FF);
        repeat (100) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - prev), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        good_frame(40'h37_00_19_00_50, 26, 70, 40'h19_00_37_00_50, 1'b0, "resume");

        // High times of 40 us decode as 0, 42 us as 1
        good_frame(40'hA5_01_16_02_BE, 40, 42, 40'h16_02_A5_01_BE, 1'b0, "thresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
